rx_engine: RTL
==============

// Module: rx_engine
// PURPOSE
//  UART receive engine, the line-side counterpart of the transmit engine: deserialises the serial
//  rx line into bytes using the same frame controls (eight, p_en, ohel) and baud index.
//  Sits between the board RX pin and the UART register/interface logic. That logic reads
//  rx_data and acknowledges with clr.
//  Detects and flags parity, framing and overrun errors.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency; the package baud table is computed for it
//  BIT_OVERRIDE 0           if nonzero, forces bit time to this many clocks and ignores baud (sim speed-up)
// PORTS
//  clk      in   1  system clock, rising edge
//  rst      in   1  asynchronous, active-LOW reset
//  rx       in   1  serial input, asynchronous to clk, idle high
//  eight    in   1  1 = 8 data bits, 0 = 7 data bits
//  p_en     in   1  1 = parity bit present
//  ohel     in   1  parity sense: 1 = odd, 0 = even
//  baud     in   4  baud index into package table
//  clr      in   1  one-cycle read acknowledge; clears rxrdy, perr, ferr, ovf
//  rx_data  out  8  received data, LSB first on the wire; bit7 = 0 in 7-bit mode
//  rxrdy    out  1  new frame available
//  perr     out  1  parity error on the frame in rx_data
//  ferr     out  1  framing error: stop bit sampled low
//  ovf      out  1  frame completed while rxrdy was still set
// BEHAVIOUR
//  - Reset (rst=0): all outputs 0; rx_data=8'h00; synchroniser flops=1; FSM=IDLE; counters=0.
//  - rx passes through a 2-flop synchroniser. All decisions use the synchronised value rxs.
//  - Bit time BT = BIT_OVERRIDE ? BIT_OVERRIDE : BAUD_DIV[baud].
//    Table: 0:333333 1:83333 2:41667 3:20833 4:10417 5:5208 6:2604 7:1736 8:868
//    9:434 10:217 11:109 12-15:868.
//  - Sample timing comes from a single down-counter. It reloads to BT/2-1 on start detect
//    and to BT-1 after each sample. A sample strobe fires when the counter reaches 0.
//  - FSM states: IDLE, START, DATA, PAR, STOP.
//    IDLE : on rxs 1->0, latch eight/p_en/ohel/baud; load half-bit count; go to START.
//    START: at strobe, if rxs=0 go to DATA with bit_cnt=0. If rxs=1 it is a false start:
//           go to IDLE, no flags change.
//    DATA : at strobe, shift rxs into the data register at bit_cnt.
//           At the last bit (7 if eight, else 6), go to PAR if p_en, else STOP.
//    PAR  : at strobe, capture parity bit; go to STOP.
//    STOP : at strobe, complete the frame (below); go to IDLE.
//  - Frame completion happens on the cycle after the STOP strobe:
//    rx_data <= data (bit7 forced 0 in 7-bit mode); rxrdy <= 1.
//    ferr <= ~stop_bit.
//    perr <= p_en & (^data_bits ^ par_bit ^ ohel_latched) != 0. Odd parity means total ones odd.
//    ovf  <= ovf | rxrdy_old.
//  - Mode inputs changing mid-frame have no effect; only the values latched at start detect apply.
//  - Simultaneous clr and frame completion: completion wins. Flags are set from the new frame
//    and ovf is computed from pre-clr rxrdy.
//  - clr with nothing pending is harmless.
//  - clr never aborts a frame in progress.
//  - A low stop bit still delivers the data with ferr=1. The FSM returns to IDLE and waits for
//    rxs high, then a new 1->0 edge, so a break does not retrigger every bit time.
//  - Latency: rxrdy rises (frame_bits - 0.5)*BT + 3 clocks (±1) after the rx falling edge.
//  - Reset mid-frame: immediate abort to reset state; no partial data is delivered.
// STRUCTURE
//  - Package uart_pkg, shared with the TX engine: BAUD_DIV table function, FSM state encoding
//    constants, and a parity helper function.
//  - One sub-module, rx_bit_timer: bit-time down-counter with load_half/load_full inputs and a
//    strobe output. The FSM, shift register and flags stay in rx_engine.
// TESTING
//  Clock 10 ns, rst low 100 ns. Bench drives rx from a behavioural TX model, or loops back
//  through the TX engine.
//  1 8N1, baud=8, send 8'h65 -> rxrdy=1, rx_data=8'h65, perr=ferr=ovf=0; clr -> rxrdy=0
//    next cycle.
//  2 7-bit, even parity (eight=0, p_en=1, ohel=0), send 7'h65 with parity bit 0 -> rx_data=8'h65,
//    perr=0. Same frame with parity bit 1 -> perr=1.
//  3 8N1 8'hA5 with stop bit driven 0 -> rx_data=8'hA5, ferr=1. No new frame until rx returns
//    high and falls again.
//  4 Glitch: rx low for 200 clocks at baud=8 (BT=868) -> FSM back to IDLE, rxrdy stays 0.
//  5 Two 8N1 frames 8'h11 then 8'h22, no clr -> rx_data=8'h22, ovf=1. Then clr -> all flags 0.
//  6 Pull rst low mid-DATA of 8'hFF -> outputs 0 immediately. After release, a clean 8'h3C
//    frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : baud table, receive FSM states and parity helper shared by TX/RX
// Revision 1.0
// ============================================================================
package uart_pkg;

  localparam int BT_W = 19;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_t;

  function automatic int baud_rate(input logic [3:0] idx);
    case (idx)
      4'd0:    return 300;
      4'd1:    return 1200;
      4'd2:    return 2400;
      4'd3:    return 4800;
      4'd4:    return 9600;
      4'd5:    return 19200;
      4'd6:    return 38400;
      4'd7:    return 57600;
      4'd8:    return 115200;
      4'd9:    return 230400;
      4'd10:   return 460800;
      4'd11:   return 921600;
      default: return 115200;
    endcase
  endfunction

  // Clocks per bit, rounded to nearest; only ever evaluated at elaboration.
  function automatic logic [BT_W-1:0] baud_div(input int clk_hz, input logic [3:0] idx);
    int rate;
    rate = baud_rate(idx);
    return BT_W'((clk_hz + rate / 2) / rate);
  endfunction

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_bit_timer.sv
`default_nettype none
// ============================================================================
// rx_bit_timer : bit-time down-counter producing the mid-bit sample strobe
// Revision 1.0
// ============================================================================
module rx_bit_timer
  import uart_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            load_half,
  input  logic            load_full,
  input  logic [BT_W-1:0] bit_time,
  output logic            strobe
);

  logic [BT_W-1:0] cnt;

  assign strobe = run && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load_half) begin
      cnt <= (bit_time >> 1) - BT_W'(1);
    end else if (load_full) begin
      cnt <= bit_time - BT_W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - BT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_engine.sv
`default_nettype none
// ============================================================================
// rx_engine : UART receiver with parity, framing and overrun detection
// Revision 1.0
// ============================================================================
module rx_engine
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BIT_OVERRIDE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       eight,
  input  logic       p_en,
  input  logic       ohel,
  input  logic [3:0] baud,
  input  logic       clr,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  logic [BT_W-1:0] bt_tab [16];
  logic [BT_W-1:0] bit_time;
  logic            sync1, rxs, rxs_d;
  rx_state_t       state;
  logic            eight_l, p_en_l, ohel_l;
  logic [3:0]      baud_l;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit, stop_bit, done;
  logic            start_det, strobe;

  for (genvar i = 0; i < 16; i++) begin : g_bt_tab
    assign bt_tab[i] = (BIT_OVERRIDE != 0) ? BT_W'(BIT_OVERRIDE) : baud_div(CLK_HZ, 4'(i));
  end

  // The half-bit load happens in the same cycle baud is latched, so use the live index in IDLE.
  assign bit_time  = bt_tab[(state == ST_IDLE) ? baud : baud_l];
  assign start_det = (state == ST_IDLE) && rxs_d && !rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  rx_bit_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (state != ST_IDLE),
    .load_half (start_det),
    .load_full (strobe),
    .bit_time  (bit_time),
    .strobe    (strobe)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      eight_l  <= 1'b0;
      p_en_l   <= 1'b0;
      ohel_l   <= 1'b0;
      baud_l   <= 4'd0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      par_bit  <= 1'b0;
      stop_bit <= 1'b0;
      done     <= 1'b0;
      rx_data  <= 8'h00;
      rxrdy    <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_det) begin
            eight_l <= eight;
            p_en_l  <= p_en;
            ohel_l  <= ohel;
            baud_l  <= baud;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (strobe) begin
            if (!rxs) begin
              bit_cnt <= 3'd0;
              shreg   <= 8'h00;
              state   <= ST_DATA;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (strobe) begin
            shreg[bit_cnt] <= rxs;
            if (bit_cnt == (eight_l ? 3'd7 : 3'd6)) begin
              state <= p_en_l ? ST_PAR : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        ST_PAR: begin
          if (strobe) begin
            par_bit <= rxs;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (strobe) begin
            stop_bit <= rxs;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Completion takes priority over a coincident clr; ovf sees the pre-clr rxrdy.
      if (done) begin
        rx_data <= {eight_l & shreg[7], shreg[6:0]};
        rxrdy   <= 1'b1;
        ferr    <= ~stop_bit;
        perr    <= p_en_l & (parity8(shreg) ^ par_bit ^ ohel_l);
        ovf     <= ovf | rxrdy;
      end else if (clr) begin
        rxrdy <= 1'b0;
        perr  <= 1'b0;
        ferr  <= 1'b0;
        ovf   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
